// File: rtl/reg_file_param.sv
// Parametrised register file: two write ports (port 1 wins collisions), two
// combinational read ports, optional bypass and zero register, and a clear engine.
module reg_file_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WRITE0,
  input  logic [ADDR_W-1:0] INADDRESS0,
  input  logic [DATA_W-1:0] IN0,
  input  logic              WRITE1,
  input  logic [ADDR_W-1:0] INADDRESS1,
  input  logic [DATA_W-1:0] IN1,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  input  logic              CLEAR_REQ,
  output logic              BUSY,
  output logic              CLEAR_DONE
);

  localparam int unsigned       DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLEARING = 2'd1,
    DONE     = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_nxt;
  logic [DATA_W-1:0] regs [DEPTH];
  logic              we0;
  logic              we1;

  // Write enables qualified by the clear engine and the hardwired zero register
  assign we0 = WRITE0 && !BUSY && !((ZERO_REG != 0) && (INADDRESS0 == '0));
  assign we1 = WRITE1 && !BUSY && !((ZERO_REG != 0) && (INADDRESS1 == '0));

  // Clear engine state register; BUSY/CLEAR_DONE are flopped from the next state
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      idx        <= '0;
      BUSY       <= 1'b0;
      CLEAR_DONE <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      BUSY       <= (state_nxt != IDLE);
      CLEAR_DONE <= (state_nxt == DONE);
    end
  end

  // Clear engine next state; idx parks on the last register instead of wrapping
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    unique case (state)
      IDLE: begin
        if (CLEAR_REQ) begin
          state_nxt = CLEARING;
          idx_nxt   = '0;
        end
      end
      CLEARING: begin
        if (idx == LAST_IDX) begin
          state_nxt = DONE;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Storage: sweep clears one entry per cycle; port 1 is written last so it wins
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[ADDR_W'(i)] <= '0;
      end
    end else if (state == CLEARING) begin
      regs[idx] <= '0;
    end else begin
      if (we0) regs[INADDRESS0] <= IN0;
      if (we1) regs[INADDRESS1] <= IN1;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] stored,
    input logic              w0,
    input logic [ADDR_W-1:0] a0,
    input logic [DATA_W-1:0] d0,
    input logic              w1,
    input logic [ADDR_W-1:0] a1,
    input logic [DATA_W-1:0] d1
  );
    logic [DATA_W-1:0] r;
    r = stored;
    if (BYPASS != 0) begin
      if (w1 && (a1 == a)) begin
        r = d1;
      end else if (w0 && (a0 == a)) begin
        r = d0;
      end
    end
    if ((ZERO_REG != 0) && (a == '0)) begin
      r = '0;
    end
    return r;
  endfunction

  assign OUT1 = read_port(OUT1ADDRESS, regs[OUT1ADDRESS], we0, INADDRESS0, IN0,
                          we1, INADDRESS1, IN1);
  assign OUT2 = read_port(OUT2ADDRESS, regs[OUT2ADDRESS], we0, INADDRESS0, IN0,
                          we1, INADDRESS1, IN1);

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: one instance with bypass, one with zero register and
// no bypass, both checked against an array/phase model of the register file.
module tb_reg_file_param;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          WRITE0, WRITE1, CLEAR_REQ;
  logic [AW-1:0] INADDRESS0, INADDRESS1, OUT1ADDRESS, OUT2ADDRESS;
  logic [DW-1:0] IN0, IN1;
  logic [DW-1:0] out1_a, out2_a, out1_b, out2_b;
  logic          busy_a, done_a, busy_b, done_b;
  logic [35:0]   got;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: stored contents per instance and sweep phase (-1 idle, 0..7 clearing, 8 done)
  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  int            phase = -1;

  reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(1)) dut_a (
    .CLK(CLK), .RESET(RESET),
    .WRITE0(WRITE0), .INADDRESS0(INADDRESS0), .IN0(IN0),
    .WRITE1(WRITE1), .INADDRESS1(INADDRESS1), .IN1(IN1),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(out1_a), .OUT2(out2_a),
    .CLEAR_REQ(CLEAR_REQ), .BUSY(busy_a), .CLEAR_DONE(done_a)
  );

  reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .CLK(CLK), .RESET(RESET),
    .WRITE0(WRITE0), .INADDRESS0(INADDRESS0), .IN0(IN0),
    .WRITE1(WRITE1), .INADDRESS1(INADDRESS1), .IN1(IN1),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(out1_b), .OUT2(out2_b),
    .CLEAR_REQ(CLEAR_REQ), .BUSY(busy_b), .CLEAR_DONE(done_b)
  );

  always #5 CLK = ~CLK;

  assign got = {out1_a, out2_a, busy_a, done_a, out1_b, out2_b, busy_b, done_b};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 500000", $time);
    $fatal(1);
  end

  function automatic logic [DW-1:0] exp_a(input logic [AW-1:0] a);
    if (phase < 0 && WRITE1 && INADDRESS1 == a) return IN1;
    if (phase < 0 && WRITE0 && INADDRESS0 == a) return IN0;
    return mem_a[a];
  endfunction

  function automatic logic [DW-1:0] exp_b(input logic [AW-1:0] a);
    if (a == '0) return '0;
    return mem_b[a];
  endfunction

  function automatic logic [35:0] exp_vec();
    logic bsy;
    logic dn;
    bsy = (phase >= 0);
    dn  = (phase == DEPTH);
    return {exp_a(OUT1ADDRESS), exp_a(OUT2ADDRESS), bsy, dn,
            exp_b(OUT1ADDRESS), exp_b(OUT2ADDRESS), bsy, dn};
  endfunction

  // Advance one clock edge and apply the same edge to the model
  task automatic tick();
    @(posedge CLK);
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a[AW'(i)] = '0;
        mem_b[AW'(i)] = '0;
      end
      phase = -1;
    end else if (phase >= 0 && phase < DEPTH) begin
      mem_a[AW'(phase)] = '0;
      mem_b[AW'(phase)] = '0;
      phase++;
    end else if (phase == DEPTH) begin
      phase = -1;
    end else begin
      if (WRITE0) begin
        mem_a[INADDRESS0] = IN0;
        if (INADDRESS0 != '0) mem_b[INADDRESS0] = IN0;
      end
      if (WRITE1) begin
        mem_a[INADDRESS1] = IN1;
        if (INADDRESS1 != '0) mem_b[INADDRESS1] = IN1;
      end
      if (CLEAR_REQ) phase = 0;
    end
    #1;
  endtask

  task automatic idle();
    RESET = 1'b0; WRITE0 = 1'b0; WRITE1 = 1'b0; CLEAR_REQ = 1'b0;
    IN0 = '0; IN1 = '0; INADDRESS0 = '0; INADDRESS1 = '0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; CLEAR_REQ = 1'b1;
    WRITE0 = 1'b1; INADDRESS0 = 3'd3; IN0 = 8'h5A;
    WRITE1 = 1'b1; INADDRESS1 = 3'd4; IN1 = 8'hC3;
    tick();
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      OUT1ADDRESS = AW'(i); OUT2ADDRESS = AW'(i + 4);
      #1;
      n_checks++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_model: got %h required %h", got, exp_vec());
      end
      n_checks++;
      if ({out1_a, out2_a, busy_a, done_a, out1_b, out2_b, busy_b, done_b} !== 36'h0) begin
        n_fail++;
        $display("FAIL reset_zero: got %h required 0", got);
      end
    end
  endtask

  task automatic test_basic_write();
    WRITE0 = 1'b1; INADDRESS0 = 3'd3; IN0 = 8'hA5;
    OUT1ADDRESS = 3'd3; OUT2ADDRESS = 3'd3;
    #1;
    n_checks++;
    if (got !== exp_vec()) begin
      n_fail++;
      $display("FAIL write_cycle: got %h required %h", got, exp_vec());
    end
    tick();
    idle();
    #1;
    n_checks++;
    if ({out1_a, out2_a, out1_b, out2_b} !== {4{8'hA5}}) begin
      n_fail++;
      $display("FAIL write_r3: got %h required %h", {out1_a, out2_a, out1_b, out2_b}, {4{8'hA5}});
    end
    for (int i = 0; i < 4; i++) begin
      OUT1ADDRESS = AW'(i); OUT2ADDRESS = AW'(i + 4);
      #1;
      n_checks++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL write_sweep: got %h required %h", got, exp_vec());
      end
    end
  endtask

  task automatic test_collision();
    WRITE0 = 1'b1; INADDRESS0 = 3'd5; IN0 = 8'h11;
    WRITE1 = 1'b1; INADDRESS1 = 3'd5; IN1 = 8'h22;
    OUT1ADDRESS = 3'd5; OUT2ADDRESS = 3'd6;
    #1;
    n_checks++;
    if (out1_a !== 8'h22) begin
      n_fail++;
      $display("FAIL collision_bypass: got %h required 22", out1_a);
    end
    tick();
    WRITE0 = 1'b1; INADDRESS0 = 3'd5; IN0 = 8'h11;
    WRITE1 = 1'b1; INADDRESS1 = 3'd6; IN1 = 8'h22;
    #1;
    n_checks++;
    if ({out1_b, out2_b} !== {8'h22, 8'h00}) begin
      n_fail++;
      $display("FAIL collision_same: got %h required 2200", {out1_b, out2_b});
    end
    tick();
    idle();
    #1;
    n_checks++;
    if ({out1_a, out2_a, out1_b, out2_b} !== {8'h11, 8'h22, 8'h11, 8'h22}) begin
      n_fail++;
      $display("FAIL collision_split: got %h required 11221122", {out1_a, out2_a, out1_b, out2_b});
    end
  endtask

  task automatic test_bypass();
    WRITE0 = 1'b1; INADDRESS0 = 3'd2; IN0 = 8'h01;
    tick();
    WRITE0 = 1'b1; INADDRESS0 = 3'd2; IN0 = 8'h3C;
    OUT1ADDRESS = 3'd2; OUT2ADDRESS = 3'd4;
    #1;
    n_checks++;
    if ({out1_a, out1_b} !== {8'h3C, 8'h01}) begin
      n_fail++;
      $display("FAIL bypass_before_edge: got %h required 3c01", {out1_a, out1_b});
    end
    tick();
    WRITE0 = 1'b1; INADDRESS0 = 3'd2; IN0 = 8'hAA;
    WRITE1 = 1'b1; INADDRESS1 = 3'd2; IN1 = 8'hBB;
    #1;
    n_checks++;
    if ({out1_a, out1_b} !== {8'hBB, 8'h3C}) begin
      n_fail++;
      $display("FAIL bypass_priority: got %h required bb3c", {out1_a, out1_b});
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (got !== exp_vec()) begin
      n_fail++;
      $display("FAIL bypass_after: got %h required %h", got, exp_vec());
    end
  endtask

  task automatic test_zero_reg();
    WRITE0 = 1'b1; INADDRESS0 = 3'd0; IN0 = 8'hFF;
    WRITE1 = 1'b1; INADDRESS1 = 3'd0; IN1 = 8'hEE;
    OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd0;
    #1;
    n_checks++;
    if ({out1_a, out1_b, out2_b} !== {8'hEE, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL zero_write_cycle: got %h required ee0000", {out1_a, out1_b, out2_b});
    end
    tick();
    idle();
    #1;
    n_checks++;
    if ({out1_a, out1_b} !== {8'hEE, 8'h00}) begin
      n_fail++;
      $display("FAIL zero_after: got %h required ee00", {out1_a, out1_b});
    end
  endtask

  task automatic test_clear();
    int busy_cycles = 0;
    int dones       = 0;
    int done_at     = -1;
    for (int i = 0; i < 4; i++) begin
      WRITE0 = 1'b1; INADDRESS0 = AW'(2 * i);     IN0 = DW'(8'h10 + 2 * i);
      WRITE1 = 1'b1; INADDRESS1 = AW'(2 * i + 1); IN1 = DW'(8'h11 + 2 * i);
      tick();
    end
    idle();
    CLEAR_REQ = 1'b1;
    WRITE0 = 1'b1; INADDRESS0 = 3'd1; IN0 = 8'h77;
    OUT1ADDRESS = 3'd7; OUT2ADDRESS = 3'd1;
    #1;
    n_checks++;
    if (got !== exp_vec()) begin
      n_fail++;
      $display("FAIL clear_request: got %h required %h", got, exp_vec());
    end
    tick();
    idle();
    WRITE1 = 1'b1; INADDRESS1 = 3'd7; IN1 = 8'h99;
    for (int c = 0; c < 12; c++) begin
      OUT1ADDRESS = 3'd7; OUT2ADDRESS = AW'((c + 1) % DEPTH);
      #1;
      n_checks++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL clear_step%0d: got %h required %h", c, got, exp_vec());
      end
      if (c == 0) begin
        n_checks++;
        if (out2_a !== 8'h77) begin
          n_fail++;
          $display("FAIL clear_req_write: got %h required 77", out2_a);
        end
      end
      if (busy_a) busy_cycles++;
      if (done_a) begin
        dones++;
        done_at = c;
      end
      if (!busy_a) WRITE1 = 1'b0;
      tick();
    end
    idle();
    n_checks++;
    if (busy_cycles !== 9 || dones !== 1 || done_at !== 8) begin
      n_fail++;
      $display("FAIL clear_timing: got busy=%0d dones=%0d at=%0d required 9 1 8",
               busy_cycles, dones, done_at);
    end
    for (int i = 0; i < 4; i++) begin
      OUT1ADDRESS = AW'(i); OUT2ADDRESS = AW'(i + 4);
      #1;
      n_checks++;
      if ({out1_a, out2_a, out1_b, out2_b} !== 32'h0) begin
        n_fail++;
        $display("FAIL clear_result: got %h required 0", {out1_a, out2_a, out1_b, out2_b});
      end
    end
  endtask

  task automatic test_held_req();
    int dones = 0;
    CLEAR_REQ = 1'b1;
    tick();
    for (int c = 0; c < 25; c++) begin
      OUT1ADDRESS = AW'($urandom); OUT2ADDRESS = AW'($urandom);
      #1;
      n_checks++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL held_step%0d: got %h required %h", c, got, exp_vec());
      end
      if (done_a) dones++;
      tick();
    end
    CLEAR_REQ = 1'b0;
    for (int k = 0; k < 20 && busy_a; k++) tick();
    n_checks++;
    if (dones !== 2 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL held_retrigger: got dones=%0d busy=%b required 2 0", dones, busy_a);
    end
  endtask

  task automatic test_reset_mid_clear();
    int dones = 0;
    WRITE0 = 1'b1; INADDRESS0 = 3'd4; IN0 = 8'h44;
    WRITE1 = 1'b1; INADDRESS1 = 3'd6; IN1 = 8'h66;
    tick();
    idle();
    CLEAR_REQ = 1'b1;
    tick();
    CLEAR_REQ = 1'b0;
    tick();
    tick();
    tick();
    RESET = 1'b1;
    OUT1ADDRESS = 3'd4; OUT2ADDRESS = 3'd6;
    #1;
    n_checks++;
    if (got !== exp_vec()) begin
      n_fail++;
      $display("FAIL midclear_before: got %h required %h", got, exp_vec());
    end
    tick();
    RESET = 1'b0;
    #1;
    n_checks++;
    if ({busy_a, done_a, busy_b, done_b, out1_a, out2_a, out1_b, out2_b} !== 36'h0) begin
      n_fail++;
      $display("FAIL midclear_reset: got %h required 0",
               {busy_a, done_a, busy_b, done_b, out1_a, out2_a, out1_b, out2_b});
    end
    for (int c = 0; c < 12; c++) begin
      if (done_a || done_b) dones++;
      tick();
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL midclear_no_done: got %0d pulses required 0", dones);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      RESET      = ($urandom_range(63) == 0);
      CLEAR_REQ  = ($urandom_range(11) == 0);
      WRITE0     = 1'($urandom);
      WRITE1     = 1'($urandom);
      INADDRESS0 = AW'($urandom);
      INADDRESS1 = AW'($urandom);
      IN0        = DW'($urandom);
      IN1        = DW'($urandom);
      OUT1ADDRESS = ($urandom_range(3) == 0) ? INADDRESS1 : AW'($urandom);
      OUT2ADDRESS = ($urandom_range(3) == 0) ? INADDRESS0 : AW'($urandom);
      #1;
      n_checks++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_%0d: got %h required %h", c, got, exp_vec());
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    OUT1ADDRESS = '0;
    OUT2ADDRESS = '0;
    test_reset();
    test_basic_write();
    test_collision();
    test_bypass();
    test_zero_reg();
    test_clear();
    test_held_req();
    test_reset_mid_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
